// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU (EX stage).
// Optional build macro DIV_FAST_PATH_EN skips iterations when the quotient is trivial.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] operand_1,
   input  logic [WIDTH-1:0] operand_2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             s1, s2, dz;
   logic [WIDTH-1:0] abs1, abs2;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] sub;

   assign s1   = is_signed & operand_1[WIDTH-1];
   assign s2   = is_signed & operand_2[WIDTH-1];
   assign abs1 = s1 ? -operand_1 : operand_1;
   assign abs2 = s2 ? -operand_2 : operand_2;
   assign dz   = (operand_2 == '0);

   // quo_q shifts dividend bits out at the top and quotient bits in at the bottom
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign ge     = rem_sh >= {1'b0, dvs_q};
   assign sub    = rem_sh[WIDTH-1:0] - dvs_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  quo_d   = abs1;
                  dvs_d   = abs2;
                  rem_d   = '0;
                  cnt_d   = '0;
                  // divide by zero keeps an all-ones quotient regardless of sign
                  qneg_d  = (s1 ^ s2) & ~dz;
                  rneg_d  = s1;
                  state_d = CALC;
`ifdef DIV_FAST_PATH_EN
                  if (dz || (abs2 > abs1)) begin
                     quo_d   = dz ? '1 : '0;
                     rem_d   = abs1;
                     state_d = FIX;
                  end
`endif
               end
            end
            CALC: begin
               quo_d = {quo_q[WIDTH-2:0], ge};
               rem_d = ge ? sub : rem_sh[WIDTH-1:0];
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  state_d = FIX;
               end
            end
            FIX: begin
               lo_d    = qneg_q ? -quo_q : quo_q;
               hi_d    = rneg_q ? -rem_q : rem_q;
               state_d = DONE;
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = ((state_q == IDLE) & start & ~flush)
               | (state_q == CALC)
               | (state_q == FIX);
   assign done = (state_q == DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors, corner sequences and random ops vs. an
// arithmetic reference model for div_unit.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

`ifdef DIV_FAST_PATH_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   always #5 clk = ~clk;

   div_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .start     (start),
      .is_signed (is_signed),
      .operand_1 (op1),
      .operand_2 (op2),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, output logic [31:0] q,
                                   output logic [31:0] r);
      int sa, sb;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
         end else begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b,
                                  input logic s);
      logic [31:0] ua, ub;
      ua = (s && a[31]) ? -a : a;
      ub = (s && b[31]) ? -b : b;
      if (FAST && (b == 0 || ub > ua)) return 3;
      return 35;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit hold, output int lat,
                         output int bcnt, output logic [31:0] q,
                         output logic [31:0] r);
      @(negedge clk);
      op1 = a;
      op2 = b;
      is_signed = s;
      start = 1'b1;
      lat = 0;
      bcnt = 0;
      q = 'x;
      r = 'x;
      for (int c = 1; c <= 60; c++) begin
         #1;
         if (done) begin
            lat = c;
            q = lo;
            r = hi;
            chk("busy_in_done", {31'b0, busy}, 32'd0);
            break;
         end
         if (busy) bcnt++;
         @(negedge clk);
         if (!hold) start = 1'b0;
         op1 = $urandom;
         op2 = $urandom;
         is_signed = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("after_done_busy", {31'b0, busy}, 32'd0);
      chk("after_done_pulse", {31'b0, done}, 32'd0);
   endtask

   task automatic check_op(input string nm, input logic [31:0] a,
                           input logic [31:0] b, input logic s,
                           input bit hold, input logic [31:0] eq,
                           input logic [31:0] er);
      int lat, bcnt, el;
      logic [31:0] q, r;
      el = exp_lat(a, b, s);
      run_op(a, b, s, hold, lat, bcnt, q, r);
      chk({nm, "_lo"}, q, eq);
      chk({nm, "_hi"}, r, er);
      chk({nm, "_lat"}, lat, el);
      chk({nm, "_busy"}, bcnt, el - 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[10];
      logic [31:0] ph, pl, a, b, eq, er;
      logic s;
      bit saw_done;

      vt[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2};
      vt[1] = '{32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE};
      vt[2] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1};
      vt[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0};
      vt[4] = '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5};
      vt[5] = '{32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
      vt[6] = '{32'd3, 32'd9, 1'b0, 32'd0, 32'd3};
      vt[7] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0};
      vt[8] = '{32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15};
      vt[9] = '{32'hFFFF_FFF7, 32'hFFFF_FFFE, 1'b1, 32'd4, 32'hFFFF_FFFF};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         check_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].s,
                  bit'(i % 2), vt[i].q, vt[i].r);
      end

      // flush on the 10th CALC cycle
      ph = hi;
      pl = lo;
      @(negedge clk);
      op1 = 32'd1000;
      op2 = 32'd3;
      is_signed = 1'b0;
      start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      flush = 1'b1;
      #1;
      chk("flush_cycle_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_next_busy", {31'b0, busy}, 32'd0);
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      chk("flush_no_done", {31'b0, saw_done}, 32'd0);
      chk("flush_hi_kept", hi, ph);
      chk("flush_lo_kept", lo, pl);
      check_op("after_flush", 32'd1000, 32'd3, 1'b0, 1'b0, 32'd333, 32'd1);

      // flush beats start in the same cycle
      @(negedge clk);
      op1 = 32'd50;
      op2 = 32'd5;
      start = 1'b1;
      flush = 1'b1;
      #1;
      chk("flush_start_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      chk("flush_start_idle", {31'b0, busy}, 32'd0);

      // async reset mid-CALC
      @(negedge clk);
      op1 = 32'd12345;
      op2 = 32'd7;
      start = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_op("after_rst", 32'd12345, 32'd7, 1'b0, 1'b1, 32'd1763, 32'd4);

      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: b = $urandom;
            1: b = 32'($urandom_range(0, 15));
            2: b = -32'($urandom_range(1, 9));
            3: b = a + 32'($urandom_range(1, 3));
            default: begin
               a = 32'($urandom_range(0, 200));
               b = 32'($urandom_range(0, 300));
            end
         endcase
         ref_div(a, b, s, eq, er);
         check_op($sformatf("rnd%0d", i), a, b, s,
                  bit'($urandom_range(0, 1)), eq, er);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
